// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared encodings for the multicycle RV32I controller and its datapath:
//   - RV32I major opcode constants
//   - alu_control codes (the ALU decodes the same values)
//   - operand-A / operand-B / result mux select encodings
//   - controller state type (binary, 4 bits)
//   - bit positions inside the ALU comparison-flag bus
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU operation codes
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd3;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   // Operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // Operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Bit positions in {zero, lt_signed, lt_unsigned, sign, overflow}
   localparam int FLAG_ZERO = 4;
   localparam int FLAG_LTS  = 3;
   localparam int FLAG_LTU  = 2;

   // Controller states, binary encoded
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_ILLEGAL  = 4'd14
   } ctrl_state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Memory request handshake between the controller and the memory system.
//   mem_req   : controller -> memory, request held until mem_ready
//   mem_write : controller -> memory, store strobe, meaningful only with mem_req
//   mem_ready : memory -> controller, current request completes this cycle
// Modports: master (controller side), slave (memory side).
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
   logic mem_req;
   logic mem_write;
   logic mem_ready;

   modport master (output mem_req, output mem_write, input mem_ready);
   modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational funct decode for OP (R-type) and OP-IMM (I-type) instructions.
// Ports:
//   funct3      in  3  instr[14:12]
//   funct7_5    in  1  instr[30]
//   is_rtype    in  1  1 = OP, 0 = OP-IMM
//   alu_control out 4  ALU operation code
// ---------------------------------------------------------------------------
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] alu_control
);

   // instr[30] selects SUB only for R-type; for ADDI that bit belongs to the
   // immediate. For shifts-right it selects SRA in both formats.
   always_comb begin
      alu_control = ALU_ADD;
      case (funct3)
         3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_control = ALU_SLL;
         3'b010:  alu_control = ALU_SLT;
         3'b011:  alu_control = ALU_SLTU;
         3'b100:  alu_control = ALU_XOR;
         3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_control = ALU_OR;
         3'b111:  alu_control = ALU_AND;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Multicycle RV32I control FSM. Sequences fetch/decode/execute/writeback and
// drives the datapath mux selects, ALU opcode and memory strobes.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   opcode/funct3/funct7_5 instruction fields from the IR
//   alu_zero_flags         {zero, lt_signed, lt_unsigned, sign, overflow}
//   memBus (master)        mem_req / mem_write out, mem_ready in
//   adr_src, ir_write, pc_write, reg_write   datapath strobes
//   alu_src_a, alu_src_b, result_src         datapath mux selects
//   alu_control            ALU operation
//   instr_retired          pulse on the last state of each instruction
//   illegal_instr          high while parked in ILLEGAL
// ---------------------------------------------------------------------------
module multicycle_controller
   import rv_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic                     funct7_5,
   input  logic [4:0]               alu_zero_flags,
   multicycle_controller_if.master  memBus,
   output logic                     adr_src,
   output logic                     ir_write,
   output logic                     pc_write,
   output logic                     reg_write,
   output logic [1:0]               alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic [1:0]               result_src,
   output logic [3:0]               alu_control,
   output logic                     instr_retired,
   output logic                     illegal_instr
);

   ctrl_state_t r_state;
   ctrl_state_t w_next;
   logic [3:0]  w_aluDecode;
   logic        w_branchTaken;
   logic        w_branchLegal;
   logic        w_unusedFlags;

   // sign and overflow are part of the flag bus but play no role in branches
   assign w_unusedFlags = ^alu_zero_flags[1:0];

   alu_decoder u_aluDecoder (
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .is_rtype    (r_state == S_EXECR),
      .alu_control (w_aluDecode)
   );

   // Branch condition from the flags of rs1 - rs2; funct3 010/011 are not
   // defined branches and divert to ILLEGAL.
   always_comb begin
      w_branchTaken = 1'b0;
      w_branchLegal = 1'b1;
      case (funct3)
         3'b000:  w_branchTaken =  alu_zero_flags[FLAG_ZERO];
         3'b001:  w_branchTaken = !alu_zero_flags[FLAG_ZERO];
         3'b100:  w_branchTaken =  alu_zero_flags[FLAG_LTS];
         3'b101:  w_branchTaken = !alu_zero_flags[FLAG_LTS];
         3'b110:  w_branchTaken =  alu_zero_flags[FLAG_LTU];
         3'b111:  w_branchTaken = !alu_zero_flags[FLAG_LTU];
         default: w_branchLegal = 1'b0;
      endcase
   end

   // Next-state logic. Memory states hold until mem_ready; DECODE dispatches
   // on the major opcode held in the IR.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (memBus.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_OP:             w_next = S_EXECR;
               OP_OPIMM:          w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR;
               OP_LUI:            w_next = S_LUI;
               OP_AUIPC:          w_next = S_AUIPC;
               default:           w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   w_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (memBus.mem_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (memBus.mem_ready) w_next = S_FETCH;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = w_branchLegal ? S_FETCH : S_ILLEGAL;
         S_JALR:     w_next = S_JAL;
         S_JAL:      w_next = S_ALUWB;
         S_LUI:      w_next = S_ALUWB;
         S_AUIPC:    w_next = S_ALUWB;
         S_ILLEGAL:  w_next = S_ILLEGAL;
         default:    w_next = S_FETCH;
      endcase
   end

   // State register; reset aborts whatever instruction is in flight.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Output decode. Everything is forced low while reset is asserted so that a
   // reset in the middle of a memory access drops mem_req in that same cycle.
   always_comb begin
      memBus.mem_req   = 1'b0;
      memBus.mem_write = 1'b0;
      adr_src          = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      alu_src_a        = SRCA_PC;
      alu_src_b        = SRCB_RS2;
      result_src       = RES_ALUOUT;
      alu_control      = ALU_AND;
      instr_retired    = 1'b0;
      illegal_instr    = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               memBus.mem_req = 1'b1;
               alu_src_a      = SRCA_PC;
               alu_src_b      = SRCB_FOUR;
               alu_control    = ALU_ADD;
               result_src     = RES_ALU;
               ir_write       = memBus.mem_ready;
               pc_write       = memBus.mem_ready;
            end
            S_DECODE: begin
               alu_src_a   = SRCA_OLDPC;
               alu_src_b   = SRCB_IMM;
               alu_control = ALU_ADD;
            end
            S_MEMADR: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_IMM;
               alu_control = ALU_ADD;
            end
            S_MEMREAD: begin
               memBus.mem_req = 1'b1;
               adr_src        = 1'b1;
            end
            S_MEMWB: begin
               result_src    = RES_MEM;
               reg_write     = 1'b1;
               instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
               memBus.mem_req   = 1'b1;
               memBus.mem_write = 1'b1;
               adr_src          = 1'b1;
               instr_retired    = memBus.mem_ready;
            end
            S_EXECR: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_RS2;
               alu_control = w_aluDecode;
            end
            S_EXECI: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_IMM;
               alu_control = w_aluDecode;
            end
            S_ALUWB: begin
               result_src    = RES_ALUOUT;
               reg_write     = 1'b1;
               instr_retired = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = SRCA_RS1;
               alu_src_b     = SRCB_RS2;
               alu_control   = ALU_SUB;
               result_src    = RES_ALUOUT;
               pc_write      = w_branchLegal && w_branchTaken;
               instr_retired = w_branchLegal;
            end
            S_JALR: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_IMM;
               alu_control = ALU_ADD;
            end
            S_JAL: begin
               alu_src_a   = SRCA_OLDPC;
               alu_src_b   = SRCB_FOUR;
               alu_control = ALU_ADD;
               result_src  = RES_ALUOUT;
               pc_write    = 1'b1;
            end
            S_LUI: begin
               alu_src_b   = SRCB_IMM;
               alu_control = ALU_LUI;
            end
            S_AUIPC: begin
               alu_src_a   = SRCA_OLDPC;
               alu_src_b   = SRCB_IMM;
               alu_control = ALU_ADD;
            end
            S_ILLEGAL: illegal_instr = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
